// File: rtl/partoserial_pkg.sv
// Shared definitions for the parallel-to-serial transmit path:
// the default comma symbol and the bit-order selection helper.
package partoserial_pkg;

  localparam logic [7:0] COM_SYM = 8'hBC;

  // idx counts positions in transmit order, so idx=0 is always the first bit on the wire
  function automatic logic bit_sel(input logic [31:0] word, input int unsigned idx,
                                   input int unsigned width, input logic msb_first);
    int unsigned pos;
    pos = msb_first ? (width - 1 - idx) : idx;
    return word[pos[4:0]];
  endfunction

endpackage

// File: rtl/partoserial_gen_word_slot_counter.sv
// Bit-slot counter for one serial word; preset to the last slot on reset so
// the first cycle out of reset is a load cycle.
module word_slot_counter
  import partoserial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk_8f,
  input  logic reset,
  output logic last_bit,
  output logic first_bit
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt;

  // Explicit compare-and-wrap keeps non-power-of-two widths legal
  always_ff @(posedge clk_8f) begin
    if (reset)
      cnt <= LAST;
    else if (cnt == LAST)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign last_bit  = (cnt == LAST) && !reset;
  assign first_bit = (cnt == '0);

endmodule

// File: rtl/partoserial_gen.sv
// Parallel-to-serial converter: accepts WIDTH-bit words on valid/ready and
// streams them gap-free, filling empty word slots with IDLE_SYM.
module partoserial_gen
  import partoserial_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] IDLE_SYM  = 32'(COM_SYM),
  parameter bit          MSB_FIRST = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             out,
  output logic             word_start,
  output logic             idle_out,
  output logic [CNT_W-1:0] idle_cnt
);

  logic             last_bit;
  logic             first_bit;
  logic [WIDTH-1:0] load_word;
  logic [WIDTH-1:0] shift_reg;

  word_slot_counter #(.WIDTH(WIDTH)) u_slot (
    .clk_8f   (clk_8f),
    .reset    (reset),
    .last_bit (last_bit),
    .first_bit(first_bit)
  );

  assign ready_out = last_bit;
  assign load_word = valid_in ? data_in : IDLE_SYM[WIDTH-1:0];

  // The first bit leaves on the load edge itself; the shift register only holds the rest
  always_ff @(posedge clk_8f) begin
    if (reset) begin
      out        <= 1'b0;
      word_start <= 1'b0;
      idle_out   <= 1'b0;
      shift_reg  <= '0;
      idle_cnt   <= '0;
    end else if (last_bit) begin
      out        <= bit_sel(32'(load_word), 0, WIDTH, MSB_FIRST);
      shift_reg  <= MSB_FIRST ? (load_word << 1) : (load_word >> 1);
      word_start <= 1'b1;
      idle_out   <= !valid_in;
      if (!valid_in && (idle_cnt != '1))
        idle_cnt <= idle_cnt + 1'b1;
    end else begin
      out        <= bit_sel(32'(shift_reg), 0, WIDTH, MSB_FIRST);
      shift_reg  <= MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
      word_start <= 1'b0;
    end
  end

  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      assert ((IDLE_SYM >> WIDTH) == 32'd0)
        else $error("partoserial_gen: IDLE_SYM does not fit in WIDTH bits");
      assert (word_start == first_bit)
        else $error("partoserial_gen: word_start out of step with slot counter");
    end
  end

endmodule

// File: tb/tb_partoserial_gen.sv
// Directed bench for partoserial_gen: MSB-first byte build, LSB-first build
// with a 2-bit idle counter, and a 10-bit build.
module tb_partoserial_gen;

  logic        clk_8f = 1'b0;
  logic        reset;

  logic [7:0]  data_m;
  logic        valid_m, ready_m, out_m, ws_m, idle_m;
  logic [15:0] cnt_m;

  logic [7:0]  data_l;
  logic        valid_l, ready_l, out_l, ws_l, idle_l;
  logic [1:0]  cnt_l;

  logic [9:0]  data_w;
  logic        valid_w, ready_w, out_w, ws_w, idle_w;
  logic [15:0] cnt_w;

  int checks = 0;
  int errors = 0;

  always #5 clk_8f = ~clk_8f;

  partoserial_gen #(.WIDTH(8), .IDLE_SYM(32'hBC), .MSB_FIRST(1'b1), .CNT_W(16)) dut (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_m), .valid_in(valid_m),
    .ready_out(ready_m), .out(out_m), .word_start(ws_m), .idle_out(idle_m), .idle_cnt(cnt_m)
  );

  partoserial_gen #(.WIDTH(8), .IDLE_SYM(32'hBC), .MSB_FIRST(1'b0), .CNT_W(2)) dut_lsb (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_l), .valid_in(valid_l),
    .ready_out(ready_l), .out(out_l), .word_start(ws_l), .idle_out(idle_l), .idle_cnt(cnt_l)
  );

  partoserial_gen #(.WIDTH(10), .IDLE_SYM(32'h17C), .MSB_FIRST(1'b1), .CNT_W(16)) dut_w10 (
    .clk_8f(clk_8f), .reset(reset), .data_in(data_w), .valid_in(valid_w),
    .ready_out(ready_w), .out(out_w), .word_start(ws_w), .idle_out(idle_w), .idle_cnt(cnt_w)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic apply_stimulus(input int sel, input bit v, input logic [31:0] d);
    case (sel)
      0: begin valid_m = v; data_m = d[7:0]; end
      1: begin valid_l = v; data_l = d[7:0]; end
      default: begin valid_w = v; data_w = d[9:0]; end
    endcase
  endtask

  task automatic step();
    @(posedge clk_8f);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
    #1;
  endtask

  // Walks one word slot (or its first nbits) on instance sel; after bit change_at the
  // next stimulus is applied so the following load edge sees it.
  task automatic check_word(input int sel, input logic [31:0] word, input int width,
                            input int nbits, input bit msb, input bit exp_idle,
                            input int exp_cnt, input int change_at, input bit nv,
                            input logic [31:0] nd);
    logic [31:0] o, ws, id, rd, ic;
    logic        exp_bit;
    for (int k = 0; k < nbits; k++) begin
      step();
      case (sel)
        0: begin o = 32'(out_m); ws = 32'(ws_m); id = 32'(idle_m); rd = 32'(ready_m); ic = 32'(cnt_m); end
        1: begin o = 32'(out_l); ws = 32'(ws_l); id = 32'(idle_l); rd = 32'(ready_l); ic = 32'(cnt_l); end
        default: begin o = 32'(out_w); ws = 32'(ws_w); id = 32'(idle_w); rd = 32'(ready_w); ic = 32'(cnt_w); end
      endcase
      exp_bit = msb ? word[width-1-k] : word[k];
      check_output($sformatf("u%0d_w%0h_out_b%0d", sel, word, k), o, 32'(exp_bit));
      check_output($sformatf("u%0d_w%0h_start_b%0d", sel, word, k), ws, 32'(k == 0));
      check_output($sformatf("u%0d_w%0h_idle_b%0d", sel, word, k), id, 32'(exp_idle));
      check_output($sformatf("u%0d_w%0h_ready_b%0d", sel, word, k), rd, 32'(k == width - 1));
      check_output($sformatf("u%0d_w%0h_icnt_b%0d", sel, word, k), ic, 32'(exp_cnt));
      if (k == change_at)
        apply_stimulus(sel, nv, nd);
    end
  endtask

  initial begin
    reset = 1'b1;
    apply_stimulus(0, 1'b0, 32'h0);
    apply_stimulus(1, 1'b0, 32'h0);
    apply_stimulus(2, 1'b0, 32'h0);

    // Reset held three cycles, then released with no data offered
    repeat (3) step();
    check_output("rst_out", 32'(out_m), 32'h0);
    check_output("rst_word_start", 32'(ws_m), 32'h0);
    check_output("rst_idle_out", 32'(idle_m), 32'h0);
    check_output("rst_idle_cnt", 32'(cnt_m), 32'h0);
    check_output("rst_ready_low", 32'(ready_m), 32'h0);
    check_output("rst_idle_cnt_lsb", 32'(cnt_l), 32'h0);
    check_output("rst_idle_cnt_w10", 32'(cnt_w), 32'h0);
    reset = 1'b0;
    #1;
    check_output("ready_after_rst", 32'(ready_m), 32'h1);

    // Three comma words, then a continuous A5/3C burst, then an idle
    check_word(0, 32'hBC, 8, 8, 1'b1, 1'b1, 1, -1, 1'b0, 32'h0);
    check_word(0, 32'hBC, 8, 8, 1'b1, 1'b1, 2, -1, 1'b0, 32'h0);
    check_word(0, 32'hBC, 8, 8, 1'b1, 1'b1, 3, 7, 1'b1, 32'hA5);
    check_word(0, 32'hA5, 8, 8, 1'b1, 1'b0, 3, 0, 1'b1, 32'h3C);
    check_word(0, 32'h3C, 8, 8, 1'b1, 1'b0, 3, 0, 1'b0, 32'h0);

    // valid_in rises mid-word: comma completes intact, FF goes out next
    check_word(0, 32'hBC, 8, 8, 1'b1, 1'b1, 4, 3, 1'b1, 32'hFF);
    check_word(0, 32'hFF, 8, 5, 1'b1, 1'b0, 4, 4, 1'b0, 32'h0);

    // Reset lands with cnt=4; the rest of FF must never appear
    reset = 1'b1;
    step();
    check_output("midrst_out", 32'(out_m), 32'h0);
    check_output("midrst_word_start", 32'(ws_m), 32'h0);
    check_output("midrst_idle_out", 32'(idle_m), 32'h0);
    check_output("midrst_idle_cnt", 32'(cnt_m), 32'h0);
    reset = 1'b0;
    #1;
    check_output("midrst_ready", 32'(ready_m), 32'h1);
    check_word(0, 32'hBC, 8, 8, 1'b1, 1'b1, 1, -1, 1'b0, 32'h0);

    // LSB-first single 01, then commas with a saturating 2-bit counter
    reset = 1'b1;
    apply_stimulus(1, 1'b1, 32'h01);
    do_reset(2);
    check_word(1, 32'h01, 8, 8, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    check_word(1, 32'hBC, 8, 8, 1'b0, 1'b1, 1, -1, 1'b0, 32'h0);
    check_word(1, 32'hBC, 8, 8, 1'b0, 1'b1, 2, -1, 1'b0, 32'h0);
    check_word(1, 32'hBC, 8, 8, 1'b0, 1'b1, 3, -1, 1'b0, 32'h0);
    check_word(1, 32'hBC, 8, 8, 1'b0, 1'b1, 3, -1, 1'b0, 32'h0);
    check_word(1, 32'hBC, 8, 8, 1'b0, 1'b1, 3, -1, 1'b0, 32'h0);

    // Ten-bit words: data then two commas, 10-cycle period
    apply_stimulus(2, 1'b1, 32'h2A5);
    do_reset(2);
    check_word(2, 32'h2A5, 10, 10, 1'b1, 1'b0, 0, 0, 1'b0, 32'h0);
    check_word(2, 32'h17C, 10, 10, 1'b1, 1'b1, 1, -1, 1'b0, 32'h0);
    check_word(2, 32'h17C, 10, 10, 1'b1, 1'b1, 2, -1, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
